// File: rtl/sub86_ifetch.sv
// sub86_ifetch: two-entry instruction word buffer with demand fetch and next-word prefetch.
// Delivers big-endian-ordered halfwords from little-endian memory words, including straddles.
module sub86_ifetch (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_ia,
    output logic [15:0] o_id,
    output logic        o_ce,
    input  logic        i_flush,
    output logic        o_imreq,
    output logic [29:0] o_ima,
    input  logic        i_imack,
    input  logic [31:0] i_imd
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_v;
    logic [29:0] r_tag [2];
    logic [31:0] r_dat [2];
    logic        r_lru;
    logic [29:0] r_ima;
    logic [29:0] w_w0, w_w1, w_req;
    logic [1:0]  w_m0, w_m1;
    logic        w_h0, w_h1, w_str, w_hit, w_need, w_fill, w_vic;
    logic [31:0] w_d0, w_d1;
    logic [63:0] w_sh;
    assign w_w0   = i_ia[31:2];
    assign w_w1   = w_w0 + 30'd1;
    assign w_str  = &i_ia[1:0];
    assign w_m0   = {r_v[1] && r_tag[1] == w_w0, r_v[0] && r_tag[0] == w_w0};
    assign w_m1   = {r_v[1] && r_tag[1] == w_w1, r_v[0] && r_tag[0] == w_w1};
    assign w_h0   = |w_m0;
    assign w_h1   = |w_m1;
    assign w_hit  = w_h0 && (!w_str || w_h1);
    assign w_d0   = w_m0[0] ? r_dat[0] : r_dat[1];
    assign w_d1   = w_m1[0] ? r_dat[0] : r_dat[1];
    // Concatenating W0+1 above W0 lets one shift serve both aligned and straddling fetches
    assign w_sh   = {w_d1, w_d0} >> {i_ia[1:0], 3'b000};
    assign o_ce   = w_hit;
    assign o_id   = w_hit ? {w_sh[7:0], w_sh[15:8]} : 16'h9090;
    assign w_need = !w_h0 || !w_h1;
    assign w_req  = w_h0 ? w_w1 : w_w0;
    assign w_fill = r_state == BUSY && i_imack;
    // Never evict the entry holding W0, so a straddle's second word cannot displace its first
    assign w_vic  = w_h0 ? w_m0[0] : r_lru;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE ? (w_need ? BUSY : IDLE) : (i_imack ? IDLE : BUSY);
    end
    always_comb begin
        o_imreq = r_state == BUSY;
        o_ima   = r_ima;
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ima <= '0;
            r_v   <= '0;
            r_lru <= 1'b0;
        end else begin
            r_ima <= (r_state == IDLE && w_need) ? w_req : r_ima;
            r_v   <= i_flush ? 2'b00 : w_fill ? (r_v | (2'b01 << w_vic)) : r_v;
            r_lru <= w_fill ? ~w_vic : w_h0 ? w_m0[0] : r_lru;
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_tag[w_vic] <= r_ima;
            r_dat[w_vic] <= i_imd;
        end
    end
endmodule

// File: tb/tb_sub86_ifetch.sv
// tb_sub86_ifetch: directed vector table plus hand-written sequences for sub86_ifetch.
module tb_sub86_ifetch;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] ia = '0, imd = '0;
    logic        flush = 1'b0, imack = 1'b0;
    logic [15:0] id;
    logic        ce, imreq;
    logic [29:0] ima;
    int          n_tests = 0, n_fail = 0;
    bit          auto_mem = 1'b1;
    int          waits = 0, cnt = 0;
    logic [31:0] mem [logic [29:0]];

    typedef struct {
        logic [31:0] ia;
        logic        ce;
        logic [15:0] id;
        logic        req;
        logic [29:0] ima;
    } vec_t;
    vec_t tbl [7];

    sub86_ifetch dut (
        .i_clk(clk), .i_rstn(rst_n), .i_ia(ia), .o_id(id), .o_ce(ce),
        .i_flush(flush), .o_imreq(imreq), .o_ima(ima), .i_imack(imack), .i_imd(imd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : ({2'b00, a} ^ 32'h5A5A5A5A);
    endfunction

    // Memory model: acknowledges after `waits` wait cycles when enabled
    initial forever begin
        @(negedge clk);
        if (auto_mem) begin
            if (imreq) begin
                if (cnt >= waits) begin
                    imack = 1'b1;
                    imd   = memw(ima);
                    cnt   = 0;
                end else begin
                    imack = 1'b0;
                    cnt++;
                end
            end else begin
                imack = 1'b0;
                cnt   = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic e_ce, input logic [15:0] e_id,
                              input logic e_req, input logic [29:0] e_ima);
        chk({nm, " ce"}, 32'(ce), 32'(e_ce));
        chk({nm, " id"}, 32'(id), 32'(e_id));
        chk({nm, " imreq"}, 32'(imreq), 32'(e_req));
        chk({nm, " ima"}, 32'(ima), 32'(e_ima));
    endtask

    task automatic step(input string nm, input logic [31:0] ia_v, input logic fl,
                        input logic ack, input logic [31:0] d, input logic e_ce,
                        input logic [15:0] e_id, input logic e_req, input logic [29:0] e_ima);
        @(negedge clk);
        ia    = ia_v;
        flush = fl;
        if (!auto_mem) begin
            imack = ack;
            imd   = d;
        end
        #1;
        expect_out(nm, e_ce, e_id, e_req, e_ima);
    endtask

    task automatic do_reset(input logic [31:0] ia_v);
        rst_n = 1'b0;
        flush = 1'b0;
        ia    = ia_v;
        if (!auto_mem) imack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        expect_out("reset", 1'b0, 16'h9090, 1'b0, 30'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        mem[30'h400] = 32'h44332211;
        mem[30'h401] = 32'h88776655;
        mem[30'h402] = 32'hCCBBAA99;
        tbl[0] = '{32'h1000, 1'b0, 16'h9090, 1'b1, 30'h400};
        tbl[1] = '{32'h1000, 1'b1, 16'h1122, 1'b0, 30'h400};
        tbl[2] = '{32'h1002, 1'b1, 16'h3344, 1'b1, 30'h401};
        tbl[3] = '{32'h1004, 1'b1, 16'h5566, 1'b0, 30'h401};
        tbl[4] = '{32'h1006, 1'b1, 16'h7788, 1'b1, 30'h402};
        tbl[5] = '{32'h1007, 1'b1, 16'h8899, 1'b0, 30'h402};
        tbl[6] = '{32'h1007, 1'b1, 16'h8899, 1'b0, 30'h402};

        // cold fetch followed by prefetching sequential stream
        do_reset(32'h1000);
        for (int i = 0; i < 7; i++)
            step($sformatf("tbl%0d", i), tbl[i].ia, 1'b0, 1'b0, 32'h0,
                 tbl[i].ce, tbl[i].id, tbl[i].req, tbl[i].ima);

        // jump while a slow prefetch is in flight
        do_reset(32'h1000);
        step("jmp1", 32'h1000, 0, 0, 0, 0, 16'h9090, 1, 30'h400);
        step("jmp2", 32'h1000, 0, 0, 0, 1, 16'h1122, 0, 30'h400);
        waits = 3;
        for (int i = 3; i <= 6; i++)
            step($sformatf("jmp%0d", i), 32'h2000, 0, 0, 0, 0, 16'h9090, 1, 30'h401);
        step("jmp7", 32'h2000, 0, 0, 0, 0, 16'h9090, 0, 30'h401);
        waits = 0;
        step("jmp8", 32'h2000, 0, 0, 0, 0, 16'h9090, 1, 30'h800);
        step("jmp9", 32'h2000, 0, 0, 0, 1, 16'h5A52, 0, 30'h800);
        step("jmp10", 32'h1004, 0, 0, 0, 1, 16'h5566, 1, 30'h801);

        // flush coinciding with acknowledge, ack in IDLE, flush on a hit
        auto_mem = 1'b0;
        do_reset(32'h1000);
        step("fl1", 32'h1000, 1, 1, 32'hDEADBEEF, 0, 16'h9090, 1, 30'h400);
        step("fl2", 32'h1000, 0, 1, 32'hCAFEF00D, 0, 16'h9090, 0, 30'h400);
        step("fl3", 32'h1000, 0, 1, 32'h44332211, 0, 16'h9090, 1, 30'h400);
        step("fl4", 32'h1000, 0, 0, 32'h0, 1, 16'h1122, 0, 30'h400);
        step("fl5", 32'h1000, 1, 0, 32'h0, 1, 16'h1122, 1, 30'h401);
        step("fl6", 32'h1000, 0, 1, 32'h88776655, 0, 16'h9090, 1, 30'h401);
        step("fl7", 32'h1000, 0, 0, 32'h0, 0, 16'h9090, 0, 30'h401);
        step("fl8", 32'h1000, 0, 0, 32'h0, 0, 16'h9090, 1, 30'h400);

        // asynchronous reset in the middle of a transaction, late ack afterwards
        do_reset(32'h1000);
        step("rs1", 32'h1000, 0, 0, 32'h0, 0, 16'h9090, 1, 30'h400);
        #2 rst_n = 1'b0;
        #1 expect_out("rs_async", 1'b0, 16'h9090, 1'b0, 30'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imack = 1'b1;
        imd   = 32'hBAADF00D;
        #1 expect_out("rs_rel", 1'b0, 16'h9090, 1'b0, 30'h0);
        step("rs2", 32'h1000, 0, 0, 32'h0, 0, 16'h9090, 1, 30'h400);
        step("rs3", 32'h1000, 0, 1, 32'h44332211, 0, 16'h9090, 1, 30'h400);
        step("rs4", 32'h1000, 0, 0, 32'h0, 1, 16'h1122, 0, 30'h400);

        // straddle with both words missing
        auto_mem = 1'b1;
        mem[30'h400] = 32'hAABBCCDD;
        mem[30'h401] = 32'h55667788;
        do_reset(32'h1003);
        step("st1", 32'h1003, 0, 0, 0, 0, 16'h9090, 1, 30'h400);
        step("st2", 32'h1003, 0, 0, 0, 0, 16'h9090, 0, 30'h400);
        step("st3", 32'h1003, 0, 0, 0, 0, 16'h9090, 1, 30'h401);
        step("st4", 32'h1003, 0, 0, 0, 1, 16'hAA88, 0, 30'h401);

        // straddle across the top of the address space
        mem[30'h3FFFFFFF] = 32'h11223344;
        mem[30'h0]        = 32'h556677AB;
        do_reset(32'hFFFFFFFF);
        step("wr1", 32'hFFFFFFFF, 0, 0, 0, 0, 16'h9090, 1, 30'h3FFFFFFF);
        step("wr2", 32'hFFFFFFFF, 0, 0, 0, 0, 16'h9090, 0, 30'h3FFFFFFF);
        step("wr3", 32'hFFFFFFFF, 0, 0, 0, 0, 16'h9090, 1, 30'h0);
        step("wr4", 32'hFFFFFFFF, 0, 0, 0, 1, 16'h11AB, 0, 30'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
